// File: rtl/shift_engine.sv
// Parametrised serial shift engine: a word is loaded in parallel, shifted out LSB- or MSB-first
// one bit per strobe while sin is captured into the same register, then handed off as rx_data.
module shift_engine #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  input  logic             shift_en,
  input  logic             sin,
  output logic             sout,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   shreg, shreg_nx;
  logic               dir, dir_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               load_fire;

  // load_ready is the only output that looks at an input in the same cycle: a consumer
  // draining DONE frees the register for a back-to-back load.
  assign load_ready = (state == IDLE) || ((state == DONE) && rx_ready);
  assign load_fire  = load_valid && load_ready;

  assign sout     = dir ? shreg[WIDTH-1] : shreg[0];
  assign rx_valid = (state == DONE);
  assign rx_data  = shreg;
  assign busy     = (state == SHIFT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_nx = state;
    shreg_nx = shreg;
    dir_nx   = dir;
    cnt_nx   = bit_cnt;

    if (abort) begin
      // Abort wins over a load offered in the same cycle; the captured word is discarded.
      state_nx = IDLE;
      shreg_nx = '0;
      dir_nx   = 1'b0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_fire) begin
            state_nx = SHIFT;
            shreg_nx = load_data;
            dir_nx   = load_dir;
            cnt_nx   = '0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            shreg_nx = dir ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};
            cnt_nx   = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WIDTH - 1)) state_nx = DONE;
          end
        end
        DONE: begin
          if (rx_ready) begin
            if (load_valid) begin
              state_nx = SHIFT;
              shreg_nx = load_data;
              dir_nx   = load_dir;
              cnt_nx   = '0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          shreg_nx = '0;
          dir_nx   = 1'b0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      dir     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      dir     <= dir_nx;
      bit_cnt <= cnt_nx;
    end
  end

endmodule
